// File: rtl/ssm_word_dispatch.sv
// Circular word FIFO that grants consecutive buffered words to requesting channels in ascending order.
// Latency: 1 cycle from push to earliest grant; same-cycle request-to-grant. Backpressure: in_rdy drops when full or flushing.
module ssm_word_dispatch #(
   parameter int DW    = 128,
   parameter int NCH   = 4,
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DW-1:0]     in_data,
   input  logic [NCH-1:0]    ch_req,
   output logic [NCH-1:0]    ch_gnt,
   output logic [NCH*DW-1:0] ch_data,
   output logic [LW-1:0]     level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic [LW-1:0] pre;
   logic [LW-1:0] npop;
   logic [AW-1:0] idx;

   assign in_rdy = (level != LW'(DEPTH)) & ~flush;
   assign push   = in_vld & in_rdy;

   // pre counts requesters below k; because grants stop once pre reaches level,
   // the granted set is always a prefix of the requesters.
   always_comb begin
      pre     = '0;
      npop    = '0;
      idx     = '0;
      ch_gnt  = '0;
      ch_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_req[k]) begin
            if (!flush && (pre < level)) begin
               idx                 = rd_ptr + pre[AW-1:0];
               ch_gnt[k]           = 1'b1;
               ch_data[k*DW +: DW] = mem[idx];
               npop                = npop + LW'(1);
            end
            pre = pre + LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_ptr + npop[AW-1:0];
         level  <= level + LW'(push) - npop;
      end
   end

endmodule
